al_w2n_arb: RTL and testbench
=============================

# al_w2n_arb

Round-robin arbiter and beat sequencer that shares one wide-to-narrow serialisation path between several upstream word sources. It grants one source at a time, captures that source's wide word in a holding register and streams it downstream as narrow beats, tagged with the source index. It sits between multiple wide producers and a single narrow consumer. The read-request and last-valid-select semantics match the team's wide-to-narrow aligner, extended to N sources.

## Interface
Parameters:
- NUM_SRC, 4, number of upstream sources (>=1, need not be a power of 2)
- DAT_IN_W, 32, upstream word width [bits]; DAT_IN_W % DAT_OUT_W = 0
- DAT_OUT_W, 8, downstream beat width [bits]; power of 2
- AL_SEL_W (local), max(1, $clog2(DAT_IN_W/DAT_OUT_W)), beat-select width
- SRC_ID_W (local), max(1, $clog2(NUM_SRC)), source index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- us_vld  in  NUM_SRC  per-source word valid
- us_last_vld_sel  in  NUM_SRC*AL_SEL_W  per-source last beat index, 0-based; source i at [i*AL_SEL_W +: AL_SEL_W]
- us_dat  in  NUM_SRC*DAT_IN_W  per-source word; source i at [i*DAT_IN_W +: DAT_IN_W]
- us_rd_rqst  out  NUM_SRC  one-hot single-cycle pop to the granted source
- ds_rdy  in  1  downstream accepts the current beat
- ds_vld  out  1  beat valid
- ds_dat  out  DAT_OUT_W  beat data
- ds_src_id  out  SRC_ID_W  index of the source that owns the current beat
- ds_last  out  1  current beat is the final beat of its word
- busy  out  1  a word is held (equals ds_vld)

## Operation
- State: IDLE / XFER, plus registers word_q, lim_q, src_q, beat_q and rr_ptr (SRC_ID_W bits).
- Grant opportunity (grant_en): state==IDLE, or state==XFER and the last beat is accepted (ds_vld & ds_last & ds_rdy).
- Arbitration: on grant_en with any us_vld set, grant g is the first set bit at or above rr_ptr, wrapping modulo NUM_SRC.
- On a grant:
  - us_rd_rqst[g]=1 in that cycle only.
  - word_q<=us_dat[g], lim_q<=us_last_vld_sel[g], src_q<=g, beat_q<=0.
  - rr_ptr<=(g+1) mod NUM_SRC; the wrap is explicit for non-power-of-2 NUM_SRC.
  - state<=XFER.
- On grant_en with no us_vld set: state<=IDLE and rr_ptr is unchanged.
- In XFER:
  - ds_vld=1, ds_dat=word_q[beat_q*DAT_OUT_W +: DAT_OUT_W], ds_src_id=src_q, ds_last=(beat_q==lim_q).
  - ds_rdy & !ds_last: beat_q<=beat_q+1.
  - ds_rdy low: all outputs and registers hold.
- In IDLE: ds_vld=0, ds_last=0. ds_dat and ds_src_id show the register contents and are don't-care.
- us_rd_rqst is combinational from state, ds_rdy and us_vld, and never has more than one bit set.
- A source may change or drop us_vld freely after its pop; the captured word is not affected.
- lim_q greater than the number of beats in a word is illegal input. The bench does not drive it.

## Timing
- Reset values: state=IDLE, word_q=0, lim_q=0, src_q=0, beat_q=0, rr_ptr=0. Outputs: ds_vld=0, ds_last=0, ds_dat=0, ds_src_id=0, busy=0, us_rd_rqst=0.
- Latency: us_vld seen in IDLE in cycle t -> pop in cycle t -> first beat valid in cycle t+1.
- Throughput: a word with lim=k occupies exactly k+1 accepted beats.
- Back-to-back words: the next grant happens in the same cycle the last beat is accepted, so there is no bubble between words.
- ds_rdy stall on the last beat delays the next grant and its pop until the beat is accepted.
- lim=0: single-beat word; ds_last=1 on its only beat.
- Reset mid-XFER: the held word is discarded with no further beats. No pop is issued while rst is asserted. Arbitration restarts at source 0.
- NUM_SRC=1: the arbiter degenerates to a fixed grant; rr_ptr stays 0.

## Test plan
- Reset then idle: all us_vld=0 for 10 cycles -> ds_vld=0 and us_rd_rqst=0 throughout.
- Single source: NUM_SRC=4, src2 word 0xDDCCBBAA, lim=3, ds_rdy=1.
  - Pop on src2 in cycle t.
  - Beats 0xAA, 0xBB, 0xCC, 0xDD in cycles t+1..t+4, all with ds_src_id=2.
  - ds_last=1 only in cycle t+4.
- Round-robin fairness: all four sources continuously valid, lim=0, ds_rdy=1.
  - Grants 0,1,2,3,0,... one per cycle.
  - ds_vld stays 1 with no bubbles.
- Back-to-back words:
  - src0 with lim=1 and src1 with lim=2 both valid.
  - src1's pop coincides with the acceptance of src0's beat 1.
  - The beat stream is 2+3 beats, contiguous.
- Stall: ds_rdy low for 3 cycles on beat 1 of a lim=3 word -> ds_dat and ds_src_id hold. No new pop occurs while stalled, even with other sources valid.
- Reset mid-word: assert rst during beat 2 of a lim=3 word.
  - Outputs go to reset values immediately (asynchronous).
  - After release, the next grant goes to the lowest valid source starting at 0.

Source files
------------

// File: rtl/al_w2n_arb.sv
// Round-robin arbiter feeding one wide-to-narrow beat sequencer.
// The granted source's word is held and streamed as beats tagged with its index.
module al_w2n_arb #(
  parameter  int NUM_SRC   = 4,
  parameter  int DAT_IN_W  = 32,
  parameter  int DAT_OUT_W = 8,
  localparam int BEATS     = DAT_IN_W / DAT_OUT_W,
  localparam int AL_SEL_W  = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int SRC_ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_SRC-1:0]           us_vld,
  input  logic [NUM_SRC*AL_SEL_W-1:0]  us_last_vld_sel,
  input  logic [NUM_SRC*DAT_IN_W-1:0]  us_dat,
  output logic [NUM_SRC-1:0]           us_rd_rqst,
  input  logic                         ds_rdy,
  output logic                         ds_vld,
  output logic [DAT_OUT_W-1:0]         ds_dat,
  output logic [SRC_ID_W-1:0]          ds_src_id,
  output logic                         ds_last,
  output logic                         busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state_reg;
  logic [DAT_IN_W-1:0]   word_reg;
  logic [AL_SEL_W-1:0]   lim_reg;
  logic [SRC_ID_W-1:0]   src_reg;
  logic [AL_SEL_W-1:0]   beat_reg;
  logic [SRC_ID_W-1:0]   rr_ptr_reg;

  logic [SRC_ID_W:0]     cand_sum [NUM_SRC];
  logic [SRC_ID_W-1:0]   cand_idx [NUM_SRC];
  logic                  grant_vld;
  logic [SRC_ID_W-1:0]   grant_idx;
  logic                  grant_en;
  logic                  do_grant;
  logic [SRC_ID_W-1:0]   rr_ptr_next;

  // Candidate k is rr_ptr+k folded back into 0..NUM_SRC-1 without a modulo.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (SRC_ID_W+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (SRC_ID_W+1)'(NUM_SRC))
                          ? SRC_ID_W'(cand_sum[gi] - (SRC_ID_W+1)'(NUM_SRC))
                          : SRC_ID_W'(cand_sum[gi]);
    end
  endgenerate

  // Scan from the far end so the nearest candidate to rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (us_vld[cand_idx[k]]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
  end

  assign ds_vld    = (state_reg == XFER);
  assign busy      = ds_vld;
  assign ds_last   = ds_vld && (beat_reg == lim_reg);
  assign ds_dat    = word_reg[beat_reg*DAT_OUT_W +: DAT_OUT_W];
  assign ds_src_id = src_reg;

  // rst gates the pop so nothing is consumed while the block is held in reset.
  assign grant_en    = !rst && ((state_reg == IDLE) || (ds_last && ds_rdy));
  assign do_grant    = grant_en && grant_vld;
  assign rr_ptr_next = (grant_idx == SRC_ID_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_rqst
      assign us_rd_rqst[gi] = do_grant && (grant_idx == SRC_ID_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      word_reg   <= '0;
      lim_reg    <= '0;
      src_reg    <= '0;
      beat_reg   <= '0;
      rr_ptr_reg <= '0;
    end else if (grant_en) begin
      if (grant_vld) begin
        state_reg  <= XFER;
        word_reg   <= us_dat[grant_idx*DAT_IN_W +: DAT_IN_W];
        lim_reg    <= us_last_vld_sel[grant_idx*AL_SEL_W +: AL_SEL_W];
        src_reg    <= grant_idx;
        beat_reg   <= '0;
        rr_ptr_reg <= rr_ptr_next;
      end else begin
        state_reg  <= IDLE;
      end
    end else if ((state_reg == XFER) && ds_rdy) begin
      beat_reg <= beat_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_al_w2n_arb.sv
// Directed bench for al_w2n_arb with NUM_SRC=4, 32-bit words, 8-bit beats.
module tb_al_w2n_arb;

  localparam int NUM_SRC = 4;
  localparam int DIN_W   = 32;
  localparam int DOUT_W  = 8;
  localparam int SEL_W   = 2;
  localparam int ID_W    = 2;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC-1:0]        us_vld;
  logic [NUM_SRC*SEL_W-1:0]  us_last_vld_sel;
  logic [NUM_SRC*DIN_W-1:0]  us_dat;
  logic [NUM_SRC-1:0]        us_rd_rqst;
  logic                      ds_rdy;
  logic                      ds_vld;
  logic [DOUT_W-1:0]         ds_dat;
  logic [ID_W-1:0]           ds_src_id;
  logic                      ds_last;
  logic                      busy;

  al_w2n_arb #(.NUM_SRC(NUM_SRC), .DAT_IN_W(DIN_W), .DAT_OUT_W(DOUT_W)) dut (
    .clk(clk), .rst(rst), .us_vld(us_vld), .us_last_vld_sel(us_last_vld_sel),
    .us_dat(us_dat), .us_rd_rqst(us_rd_rqst), .ds_rdy(ds_rdy), .ds_vld(ds_vld),
    .ds_dat(ds_dat), .ds_src_id(ds_src_id), .ds_last(ds_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] vld_drv;
    logic       rdy;
    logic       v;
    logic [7:0] d;
    logic [1:0] s;
    logic       l;
    logic [3:0] r;
  } vec_t;

  // src0 lim=1 then src1 lim=2, second pop on src0's last beat
  vec_t b2b_vec [6] = '{
    '{4'b0011, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0001},
    '{4'b0010, 1'b1, 1'b1, 8'h11, 2'd0, 1'b0, 4'b0000},
    '{4'b0010, 1'b1, 1'b1, 8'h22, 2'd0, 1'b1, 4'b0010},
    '{4'b0000, 1'b1, 1'b1, 8'h31, 2'd1, 1'b0, 4'b0000},
    '{4'b0000, 1'b1, 1'b1, 8'h32, 2'd1, 1'b0, 4'b0000},
    '{4'b0000, 1'b1, 1'b1, 8'h33, 2'd1, 1'b1, 4'b0000}
  };

  // src2 lim=3 stalled on beat 1 while src0/src3 wait, then src3 follows
  vec_t stall_vec [10] = '{
    '{4'b1101, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0100},
    '{4'b1001, 1'b1, 1'b1, 8'h41, 2'd2, 1'b0, 4'b0000},
    '{4'b1001, 1'b0, 1'b1, 8'h42, 2'd2, 1'b0, 4'b0000},
    '{4'b1001, 1'b0, 1'b1, 8'h42, 2'd2, 1'b0, 4'b0000},
    '{4'b1001, 1'b0, 1'b1, 8'h42, 2'd2, 1'b0, 4'b0000},
    '{4'b1001, 1'b1, 1'b1, 8'h42, 2'd2, 1'b0, 4'b0000},
    '{4'b1001, 1'b1, 1'b1, 8'h43, 2'd2, 1'b0, 4'b0000},
    '{4'b1001, 1'b1, 1'b1, 8'h44, 2'd2, 1'b1, 4'b1000},
    '{4'b0000, 1'b1, 1'b1, 8'h51, 2'd3, 1'b0, 4'b0000},
    '{4'b0000, 1'b1, 1'b1, 8'h52, 2'd3, 1'b0, 4'b0000}
  };

  logic [7:0] single_bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat_chk(input string tag, input logic v, input logic [7:0] d,
                          input logic [1:0] s, input logic l, input logic [3:0] r);
    $display("t=%0t %s: vld=%0b dat=%02h src=%0d last=%0b rqst=%04b", $time, tag,
             ds_vld, ds_dat, ds_src_id, ds_last, us_rd_rqst);
    check({tag, ".vld"},  32'(ds_vld), 32'(v));
    check({tag, ".busy"}, 32'(busy), 32'(v));
    check({tag, ".last"}, 32'(ds_last), 32'(l));
    check({tag, ".rqst"}, 32'(us_rd_rqst), 32'(r));
    if (v) begin
      check({tag, ".dat"}, 32'(ds_dat), 32'(d));
      check({tag, ".src"}, 32'(ds_src_id), 32'(s));
    end
  endtask

  task automatic reset_chk(input string tag);
    beat_chk(tag, 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
    check({tag, ".dat0"}, 32'(ds_dat), 32'h0);
    check({tag, ".src0"}, 32'(ds_src_id), 32'h0);
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] dat, input logic [1:0] lim);
    us_dat[i*DIN_W +: DIN_W]          = dat;
    us_last_vld_sel[i*SEL_W +: SEL_W] = lim;
  endtask

  task automatic do_reset;
    us_vld = '0;
    rst    = 1'b1;
    next;
    next;
    rst    = 1'b0;
  endtask

  initial begin
    rst             = 1'b1;
    us_vld          = '0;
    us_dat          = '0;
    us_last_vld_sel = '0;
    ds_rdy          = 1'b1;
    next;
    #3 reset_chk("reset");
    next;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      #3 beat_chk($sformatf("idle%0d", i), 1'b0, 8'h00, 2'd0, 1'b0, 4'b0000);
      next;
    end

    // single source: src2, lim=3
    set_word(2, 32'hDDCCBBAA, 2'd3);
    us_vld = 4'b0100;
    #3 beat_chk("single.pop", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0100);
    next;
    us_vld = '0;
    for (int i = 0; i < 4; i++) begin
      #3 beat_chk($sformatf("single.beat%0d", i), 1'b1, single_bytes[i], 2'd2, (i == 3), 4'b0000);
      next;
    end

    // round robin: all valid, lim=0
    do_reset;
    for (int i = 0; i < NUM_SRC; i++) set_word(i, 32'h10 + 32'(i), 2'd0);
    us_vld = 4'b1111;
    #3 beat_chk("rr0", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0001);
    next;
    for (int j = 1; j <= 8; j++) begin
      #3 beat_chk($sformatf("rr%0d", j), 1'b1, 8'h10 + 8'((j - 1) % 4), 2'((j - 1) % 4),
                  1'b1, 4'b0001 << (j % 4));
      next;
    end
    us_vld = '0;
    #3 beat_chk("rr_tail", 1'b1, 8'h10, 2'd0, 1'b1, 4'b0000);
    next;

    // back-to-back words
    do_reset;
    set_word(0, 32'h00002211, 2'd1);
    set_word(1, 32'h00333231, 2'd2);
    for (int i = 0; i < 6; i++) begin
      us_vld = b2b_vec[i].vld_drv;
      ds_rdy = b2b_vec[i].rdy;
      #3 beat_chk($sformatf("b2b%0d", i), b2b_vec[i].v, b2b_vec[i].d, b2b_vec[i].s,
                  b2b_vec[i].l, b2b_vec[i].r);
      next;
    end

    // stall on beat 1 with competing sources
    set_word(2, 32'h44434241, 2'd3);
    set_word(3, 32'h54535251, 2'd3);
    for (int i = 0; i < 10; i++) begin
      us_vld = stall_vec[i].vld_drv;
      ds_rdy = stall_vec[i].rdy;
      #3 beat_chk($sformatf("stall%0d", i), stall_vec[i].v, stall_vec[i].d, stall_vec[i].s,
                  stall_vec[i].l, stall_vec[i].r);
      next;
    end

    // reset asserted mid-word during beat 2 of src3
    us_vld = 4'b1010;
    ds_rdy = 1'b1;
    #1 beat_chk("midrst.beat2", 1'b1, 8'h53, 2'd3, 1'b0, 4'b0000);
    rst = 1'b1;
    #1 reset_chk("midrst.async");
    next;
    #3 reset_chk("midrst.held");
    next;
    rst = 1'b0;
    #3 beat_chk("midrst.pop", 1'b0, 8'h00, 2'd0, 1'b0, 4'b0010);
    next;
    us_vld = '0;
    #3 beat_chk("midrst.beat0", 1'b1, 8'h31, 2'd1, 1'b0, 4'b0000);
    next;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
